// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & 32'hffff_fffc;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue of {pc, instr} entries with flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count,
    output fetch_entry_t           o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, halt window and redirect arbitration for fetch
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd32,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   r_pc;
    logic          r_halted;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    logic [31:0]   w_pc_next;
    logic [31:0]   w_redirect_target;
    logic          w_push;
    logic          w_pop;

    assign w_redirect_target = align_pc(redirect_pc);
    assign w_pc_next         = r_pc + 32'd4;
    assign w_entry           = '{pc: r_pc, instr: imem_instr};

    // Redirect discards the queue, so it blocks both the pop and the push of that cycle.
    assign w_pop  = !w_empty && out_ready && !redirect_valid;
    assign w_push = !reset && !redirect_valid && !r_halted && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_pc     <= w_redirect_target;
            r_halted <= (w_redirect_target >= PC_LIMIT);
        end else if (w_push) begin
            r_pc <= w_pc_next;
            if (w_pc_next == PC_LIMIT) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_pc   = r_pc;
    assign halted    = r_halted;
    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule
